// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the multi-word ALU sequencer:
//   alu_mode_e  - mode codes driven onto the pipeline ALU control input
//   OP_ADD/SUB  - sequencer operation encoding on op_i
//   seq_state_e - sequencer FSM states
//   limb_mode() - picks the ALU mode for a limb from op and first-limb flag
// -----------------------------------------------------------------------------
package alu_seq_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_ADDC = 3'd2,
        ALU_SUBC = 3'd3,
        ALU_AND  = 3'd4,
        ALU_OR   = 3'd5,
        ALU_XOR  = 3'd6,
        ALU_PASS = 3'd7
    } alu_mode_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    // The first limb has no incoming carry; later limbs chain through ADDC/SUBC.
    function automatic alu_mode_e limb_mode(input logic op, input logic first);
        if (first) return (op == OP_SUB) ? ALU_SUB  : ALU_ADD;
        else       return (op == OP_SUB) ? ALU_SUBC : ALU_ADDC;
    endfunction

endpackage

// File: rtl/alu_mw_seq.sv
// -----------------------------------------------------------------------------
// alu_mw_seq
// Multi-precision add/subtract sequencer. After a start request it streams
// 32-bit limb pairs (least significant first) through the shared ALU, threading
// carry/borrow between limbs, and returns one result limb per input limb plus
// the final carry/borrow and signed-overflow flags.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start_i, op_i,        start request (sampled in IDLE), 0=add 1=sub (A-B),
//   nwords_i              limb count (saturates to MAX_WORDS, 0 = no-op)
//   busy_o, done_o        not-IDLE indicator, one-cycle completion pulse
//   limb_valid_i/ready_o  operand limb handshake, limb_a_i/limb_b_i data
//   res_valid_o/ready_i   result limb handshake, res_data_o, res_last_o
//   flag_c_o, flag_v_o    final carry/borrow and signed overflow
//   alu_srcA_o/srcB_o     ALU operands (srcB bit 32 = carry-in)
//   alu_ctrl_o            ALU mode (alu_mode_e)
//   alu_result_i, alu_C_flag_i, alu_V_flag_i   ALU response (combinational)
//
// Optional build macro ALU_MW_SEQ_ZFLAG_EN adds flag_z_o: 1 when every result
// limb of the last operation was zero (1 for a zero-length operation).
// -----------------------------------------------------------------------------
module alu_mw_seq
    import alu_seq_pkg::*;
#(
    parameter  int MAX_WORDS = 8,
    localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             op_i,
    input  logic [CNT_W-1:0] nwords_i,
    output logic             busy_o,
    input  logic             limb_valid_i,
    output logic             limb_ready_o,
    input  logic [31:0]      limb_a_i,
    input  logic [31:0]      limb_b_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [31:0]      res_data_o,
    output logic             res_last_o,
    output logic             done_o,
    output logic             flag_c_o,
    output logic             flag_v_o,
`ifdef ALU_MW_SEQ_ZFLAG_EN
    output logic             flag_z_o,
`endif
    output logic [33:0]      alu_srcA_o,
    output logic [33:0]      alu_srcB_o,
    output logic [2:0]       alu_ctrl_o,
    input  logic [31:0]      alu_result_i,
    input  logic             alu_C_flag_i,
    input  logic             alu_V_flag_i
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    seq_state_e       state_q;
    logic             op_q;
    logic [CNT_W-1:0] nwords_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;

    logic first_limb;
    logic last_limb;
    logic limb_hs;
    logic res_hs;
    logic lost;
    logic carry_next;

    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    // A new limb may enter only if the result register is free or being drained.
    assign limb_ready_o = (state_q == RUN) & (~res_valid_o | res_ready_i);
    assign limb_hs      = limb_valid_i & limb_ready_o;
    assign res_hs       = res_valid_o & res_ready_i;

    assign first_limb = (cnt_q == '0);
    assign last_limb  = (cnt_q == nwords_q - CNT_ONE);

    // The ALU folds carry-in into B within 32 bits; B=all-ones plus a carry
    // wraps to zero, so the ALU reports no carry although the true one is 1.
    assign lost       = ~first_limb & carry_q & (limb_b_i == 32'hFFFF_FFFF);
    assign carry_next = alu_C_flag_i | lost;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        alu_srcA_o = '0;
        alu_srcB_o = '0;
        alu_ctrl_o = ALU_PASS;
        if (state_q == RUN) begin
            alu_srcA_o = {2'b00, limb_a_i};
            alu_srcB_o = {1'b0, carry_q, limb_b_i};
            alu_ctrl_o = limb_mode(op_q, first_limb);
        end
    end

`ifdef ALU_MW_SEQ_ZFLAG_EN
    logic zero_acc_q;
    logic zero_next;
    assign zero_next = zero_acc_q & (alu_result_i == 32'h0);
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_ADD;
            nwords_q    <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            res_valid_o <= 1'b0;
            res_data_o  <= '0;
            res_last_o  <= 1'b0;
            flag_c_o    <= 1'b0;
            flag_v_o    <= 1'b0;
`ifdef ALU_MW_SEQ_ZFLAG_EN
            zero_acc_q  <= 1'b0;
            flag_z_o    <= 1'b0;
`endif
        end else begin
            // Consumed result frees the register; a same-cycle capture below
            // overrides this.
            if (res_hs) begin
                res_valid_o <= 1'b0;
                res_last_o  <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (nwords_i == '0) begin
                            flag_c_o <= 1'b0;
                            flag_v_o <= 1'b0;
`ifdef ALU_MW_SEQ_ZFLAG_EN
                            flag_z_o <= 1'b1;
`endif
                            state_q  <= DONE;
                        end else begin
                            op_q     <= op_i;
                            nwords_q <= (nwords_i > MAX_CNT) ? MAX_CNT : nwords_i;
                            cnt_q    <= '0;
                            carry_q  <= 1'b0;
`ifdef ALU_MW_SEQ_ZFLAG_EN
                            zero_acc_q <= 1'b1;
`endif
                            state_q  <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (limb_hs) begin
                        res_data_o  <= alu_result_i;
                        res_valid_o <= 1'b1;
                        res_last_o  <= last_limb;
                        carry_q     <= carry_next;
                        cnt_q       <= cnt_q + CNT_ONE;
`ifdef ALU_MW_SEQ_ZFLAG_EN
                        zero_acc_q  <= zero_next;
`endif
                        if (last_limb) begin
                            flag_c_o <= carry_next;
                            flag_v_o <= alu_V_flag_i;
`ifdef ALU_MW_SEQ_ZFLAG_EN
                            flag_z_o <= zero_next;
`endif
                            state_q  <= DRAIN;
                        end
                    end
                end

                // Only the final limb can be pending here.
                DRAIN: begin
                    if (res_hs) state_q <= DONE;
                end

                DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mw_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_mw_seq
// Self-checking bench for alu_mw_seq. A behavioural ALU model answers the
// sequencer's ALU requests; expected results come from hand-written vectors
// and from a whole-number reference model of multi-precision add/subtract.
// -----------------------------------------------------------------------------
module tb_alu_mw_seq;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_i;
    logic             op_i;
    logic [CNT_W-1:0] nwords_i;
    logic             busy_o;
    logic             limb_valid_i;
    logic             limb_ready_o;
    logic [31:0]      limb_a_i;
    logic [31:0]      limb_b_i;
    logic             res_valid_o;
    logic             res_ready_i;
    logic [31:0]      res_data_o;
    logic             res_last_o;
    logic             done_o;
    logic             flag_c_o;
    logic             flag_v_o;
    logic [33:0]      alu_srcA_o;
    logic [33:0]      alu_srcB_o;
    logic [2:0]       alu_ctrl_o;
    logic [31:0]      alu_result_i;
    logic             alu_C_flag_i;
    logic             alu_V_flag_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_mw_seq #(.MAX_WORDS(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .op_i         (op_i),
        .nwords_i     (nwords_i),
        .busy_o       (busy_o),
        .limb_valid_i (limb_valid_i),
        .limb_ready_o (limb_ready_o),
        .limb_a_i     (limb_a_i),
        .limb_b_i     (limb_b_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_data_o   (res_data_o),
        .res_last_o   (res_last_o),
        .done_o       (done_o),
        .flag_c_o     (flag_c_o),
        .flag_v_o     (flag_v_o),
        .alu_srcA_o   (alu_srcA_o),
        .alu_srcB_o   (alu_srcB_o),
        .alu_ctrl_o   (alu_ctrl_o),
        .alu_result_i (alu_result_i),
        .alu_C_flag_i (alu_C_flag_i),
        .alu_V_flag_i (alu_V_flag_i)
    );

    // ALU model: carry modes fold cin into B within 32 bits (so the carry of
    // B=all-ones plus cin is lost); V is the exact signed overflow of A op B op cin.
    always_comb begin
        logic [31:0] a, b, bb;
        longint      s, ci;
        a  = alu_srcA_o[31:0];
        b  = alu_srcB_o[31:0];
        ci = 0;
        if (alu_ctrl_o == 3'd2 || alu_ctrl_o == 3'd3) ci = longint'(alu_srcB_o[32]);
        bb = b + 32'(ci);
        s  = 0;
        alu_result_i = a;
        alu_C_flag_i = 1'b0;
        alu_V_flag_i = 1'b0;
        if (alu_ctrl_o == 3'd0 || alu_ctrl_o == 3'd2) begin
            {alu_C_flag_i, alu_result_i} = {1'b0, a} + {1'b0, bb};
            s = longint'($signed(a)) + longint'($signed(b)) + ci;
            alu_V_flag_i = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (alu_ctrl_o == 3'd1 || alu_ctrl_o == 3'd3) begin
            alu_result_i = a - bb;
            alu_C_flag_i = (a < bb);
            s = longint'($signed(a)) - longint'($signed(b)) - ci;
            alu_V_flag_i = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
    end

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Whole-number reference: n-limb operands treated as single integers.
    function automatic void ref_op(input logic op, input int n, input logic [255:0] a,
                                   input logic [255:0] b, output logic [255:0] r,
                                   output logic c, output logic v);
        logic [256:0] mask, am, bm, s;
        logic sa, sb, sr;
        mask = (257'd1 << (32 * n)) - 257'd1;
        am = {1'b0, a} & mask;
        bm = {1'b0, b} & mask;
        if (!op) begin
            s = am + bm;
            c = s[32 * n];
        end else begin
            s = am - bm;
            c = (am < bm);
        end
        s  = s & mask;
        r  = s[255:0];
        sa = am[32 * n - 1];
        sb = bm[32 * n - 1];
        sr = s[32 * n - 1];
        v  = op ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    endfunction

    function automatic logic [31:0] pick_limb();
        case ($urandom_range(0, 5))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Runs one operation end to end, checking handshake/timing properties,
    // and returns the collected result limbs and the final flags.
    task automatic run_op(input string tag, input logic op, input logic [CNT_W-1:0] nreq,
                          input logic [255:0] a, input logic [255:0] b,
                          input bit stall, input bit noisy,
                          output logic [255:0] res, output int nres,
                          output logic c, output logic v);
        int n_eff, sent, cyc, last_hs, done_cyc, stall_left, stall_seen;
        bit stall_started, prev_stall, ctrl_ok, last_ok, hold_ok, ready_seen;
        logic [31:0] prev_data;
        logic [2:0]  exp_ctrl;
        n_eff = (nreq > 4'd8) ? 8 : int'(nreq);
        sent = 0; nres = 0; cyc = 0; last_hs = -10; done_cyc = -1;
        stall_left = 0; stall_seen = 0; stall_started = 0; prev_stall = 0;
        ctrl_ok = 1; last_ok = 1; hold_ok = 1; ready_seen = 0;
        prev_data = '0; res = '0;

        op_i = op; nwords_i = nreq; start_i = 1'b1;
        @(posedge clk); #1;
        while (done_cyc < 0 && cyc < 300) begin
            start_i = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            if (stall && !stall_started && res_valid_o) begin
                stall_started = 1;
                stall_left = 3;
            end
            if (stall_left > 0) begin
                res_ready_i = 1'b0;
                stall_left--;
            end else begin
                res_ready_i = noisy ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (sent < n_eff) begin
                limb_valid_i = noisy ? ($urandom_range(0, 2) != 0) : 1'b1;
                limb_a_i = a[32 * sent +: 32];
                limb_b_i = b[32 * sent +: 32];
            end else begin
                limb_valid_i = 1'b0;
                limb_a_i = '0;
                limb_b_i = '0;
            end
            #1;
            if (limb_ready_o) ready_seen = 1;
            if (done_o) done_cyc = cyc;
            if (res_valid_o && !res_ready_i) begin
                stall_seen++;
                if (prev_stall && res_data_o !== prev_data) hold_ok = 0;
                if (limb_ready_o) hold_ok = 0;
                prev_stall = 1;
                prev_data = res_data_o;
            end else begin
                prev_stall = 0;
            end
            if (res_valid_o && res_ready_i) begin
                if (nres < 8) res[32 * nres +: 32] = res_data_o;
                if (res_last_o !== (nres == n_eff - 1)) last_ok = 0;
                nres++;
                last_hs = cyc;
            end
            if (limb_valid_i && limb_ready_o) begin
                exp_ctrl = (sent == 0) ? {2'b00, op} : {2'b01, op};
                if (alu_ctrl_o !== exp_ctrl) ctrl_ok = 0;
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start_i = 1'b0; limb_valid_i = 1'b0; res_ready_i = 1'b0;

        check({tag, " done_seen"}, done_cyc >= 0, 1'b1);
        check({tag, " done_timing"}, done_cyc, (n_eff == 0) ? 0 : last_hs + 1);
        check({tag, " done_one_cycle"}, done_o, 1'b0);
        check({tag, " idle_after"}, busy_o, 1'b0);
        check({tag, " result_count"}, nres, n_eff);
        check({tag, " alu_ctrl_seq"}, ctrl_ok, 1'b1);
        check({tag, " res_last"}, last_ok, 1'b1);
        check({tag, " stall_hold"}, hold_ok, 1'b1);
        if (stall) check({tag, " stall_cycles"}, stall_seen, 3);
        if (n_eff == 0) check({tag, " no_limb_ready"}, ready_seen, 1'b0);
        c = flag_c_o;
        v = flag_v_o;
    endtask

    typedef struct {
        logic             op;
        logic [CNT_W-1:0] n;
        logic [255:0]     a;
        logic [255:0]     b;
        logic [255:0]     res;
        logic             c;
        logic             v;
        bit               stall;
    } vec_t;

    vec_t         vecs[9];
    logic [255:0] got_res;
    int           got_n;
    logic         got_c, got_v;
    int           done_cnt;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start_i = 1'b0; op_i = 1'b0; nwords_i = '0;
        limb_valid_i = 1'b0; limb_a_i = '0; limb_b_i = '0; res_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state.
        check("rst busy", busy_o, 1'b0);
        check("rst limb_ready", limb_ready_o, 1'b0);
        check("rst res_valid", res_valid_o, 1'b0);
        check("rst res_data", res_data_o, 32'h0);
        check("rst res_last", res_last_o, 1'b0);
        check("rst done", done_o, 1'b0);
        check("rst flag_c", flag_c_o, 1'b0);
        check("rst flag_v", flag_v_o, 1'b0);
        check("rst srcA", alu_srcA_o, 34'h0);
        check("rst srcB", alu_srcB_o, 34'h0);
        check("rst ctrl", alu_ctrl_o, 3'd7);
        rst_n = 1'b1;
        @(posedge clk); #1;

        //         op    n      a                             b                             res                                  c     v     stall
        vecs[0] = '{1'b0, 4'd2, 256'h1_FFFFFFFF,              256'h1,                       256'h2_00000000,                     1'b0, 1'b0, 0};
        vecs[1] = '{1'b1, 4'd1, 256'h0,                       256'h1,                       256'hFFFFFFFF,                       1'b1, 1'b0, 0};
        vecs[2] = '{1'b0, 4'd2, 256'h12345678_FFFFFFFF,       256'hFFFFFFFF_00000001,       256'h12345678_00000000,              1'b1, 1'b0, 0};
        vecs[3] = '{1'b0, 4'd1, 256'h7FFFFFFF,                256'h1,                       256'h80000000,                       1'b0, 1'b1, 0};
        vecs[4] = '{1'b0, 4'd3, 256'h3_00000002_00000001,     256'h30_00000020_00000010,    256'h33_00000022_00000011,           1'b0, 1'b0, 1};
        vecs[5] = '{1'b1, 4'd3, 256'h5_00000000,              256'hFFFFFFFF_00000001,       256'hFFFFFFFF_00000005_FFFFFFFF,     1'b1, 1'b0, 0};
        vecs[6] = '{1'b1, 4'd1, 256'h80000000,                256'h1,                       256'h7FFFFFFF,                       1'b0, 1'b1, 0};
        vecs[7] = '{1'b0, 4'd15, {256{1'b1}},                 256'h1,                       256'h0,                              1'b1, 1'b0, 0};
        vecs[8] = '{1'b0, 4'd0, 256'h1234,                    256'h5678,                    256'h0,                              1'b0, 1'b0, 0};

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].n, vecs[i].a, vecs[i].b,
                   vecs[i].stall, 1'b0, got_res, got_n, got_c, got_v);
            check($sformatf("vec%0d result", i), got_res, vecs[i].res);
            check($sformatf("vec%0d flag_c", i), got_c, vecs[i].c);
            check($sformatf("vec%0d flag_v", i), got_v, vecs[i].v);
        end

        // Reset in the middle of RUN: abort, back to IDLE, no done pulse.
        op_i = 1'b0; nwords_i = 4'd4; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; res_ready_i = 1'b1; limb_valid_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            limb_a_i = 32'(k + 1); limb_b_i = 32'h0;
            @(posedge clk); #1;
        end
        check("midrst busy_before", busy_o, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; limb_valid_i = 1'b0;
        check("midrst busy", busy_o, 1'b0);
        check("midrst res_valid", res_valid_o, 1'b0);
        check("midrst limb_ready", limb_ready_o, 1'b0);
        check("midrst ctrl", alu_ctrl_o, 3'd7);
        check("midrst flag_c", flag_c_o, 1'b0);
        done_cnt = 0;
        if (done_o) done_cnt++;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done_o) done_cnt++;
        end
        check("midrst no_done", done_cnt, 0);
        res_ready_i = 1'b0;

        // Randomized operations against the whole-number reference model.
        for (int t = 0; t < 40; t++) begin
            logic             rop, rc, rv;
            logic [CNT_W-1:0] rn;
            logic [255:0]     ra, rb, rres;
            int               ne;
            rop = 1'($urandom_range(0, 1));
            rn  = CNT_W'($urandom_range(1, 10));
            ne  = (rn > 4'd8) ? 8 : int'(rn);
            for (int k = 0; k < 8; k++) begin
                ra[32 * k +: 32] = pick_limb();
                rb[32 * k +: 32] = pick_limb();
            end
            ref_op(rop, ne, ra, rb, rres, rc, rv);
            run_op($sformatf("rnd%0d", t), rop, rn, ra, rb, 0, 1,
                   got_res, got_n, got_c, got_v);
            check($sformatf("rnd%0d result", t), got_res, rres);
            check($sformatf("rnd%0d flag_c", t), got_c, rc);
            check($sformatf("rnd%0d flag_v", t), got_v, rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mw_seq.md
Name: alu_mw_seq

Overview:
- Multi-word (multi-precision) add/subtract sequencer for the pipeline ALU.
- Accepts an operation and a word count, then streams 32-bit limb pairs, least significant first, through the shared ALU.
- Issues ADD/SUB on the first limb and ADDC/SUBC on later limbs, threading the carry/borrow between them.
- Sits between the extended-arithmetic issue logic and the ALU input muxes; returns result limbs plus final C/V flags.

Parameters:
- MAX_WORDS, 8, maximum limbs per operation; larger requests saturate to this.
- CNT_W, $clog2(MAX_WORDS+1), width of the word count and internal counter (derived; do not override).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start_i  in  1  start request; sampled only in IDLE
- op_i  in  1  0=add, 1=subtract (A-B)
- nwords_i  in  CNT_W  limb count
- busy_o  out  1  high in any state except IDLE
- limb_valid_i  in  1  limb pair valid
- limb_ready_o  out  1  sequencer accepts limb pair
- limb_a_i  in  32  operand A limb
- limb_b_i  in  32  operand B limb
- res_valid_o  out  1  result limb valid
- res_ready_i  in  1  consumer accepts result
- res_data_o  out  32  result limb
- res_last_o  out  1  marks the most significant result limb
- done_o  out  1  one-cycle completion pulse
- flag_c_o  out  1  final carry (add) or borrow (sub)
- flag_v_o  out  1  final signed overflow
- alu_srcA_o  out  34  to ALU srcA
- alu_srcB_o  out  34  to ALU srcB; bit 32 = carry-in
- alu_ctrl_o  out  3  to ALU mode
- alu_result_i  in  32  from ALU
- alu_C_flag_i  in  1  from ALU
- alu_V_flag_i  in  1  from ALU

Behaviour:
- Reset values: state IDLE; all outputs 0 except alu_ctrl_o=PASS(7); carry_q=0; counter=0.
- Reset is synchronous. Asserting it mid-operation aborts the operation: partial results are dropped and no done_o is issued.

State machine:
- IDLE:
  - start_i=1, nwords_i=0: go to DONE.
  - start_i=1, nwords_i>0: latch op_i and min(nwords_i, MAX_WORDS), clear carry_q, go to RUN.
- RUN:
  - limb_ready_o = !res_valid_o | res_ready_i.
  - A limb handshake (limb_valid_i & limb_ready_o) increments the counter. On the last limb, go to DRAIN.
- DRAIN: wait for the last result handshake, then go to DONE.
- DONE: done_o=1 for exactly one cycle, then go to IDLE.
- start_i is ignored whenever busy_o=1.

ALU drive (combinational in RUN, otherwise PASS with zero sources):
- alu_srcA_o = {2'b0, limb_a_i}.
- alu_srcB_o = {1'b0, carry_q, limb_b_i}.
- alu_ctrl_o:
  - First limb: ADD(0) or SUB(1).
  - Later limbs: ADDC(2) or SUBC(3).

Result capture (latency 1 cycle):
- On a handshake, register alu_result_i into res_data_o and set res_valid_o.
- res_last_o is set with the final limb.
- res_valid_o stays high until res_ready_i; res_data_o is held stable while stalled.

Carry update on each handshake:
- carry_q <= alu_C_flag_i | lost, where lost = carry_q & (limb_b_i == 32'hFFFFFFFF) on ADDC/SUBC.
- Reason: the ALU forms B+cin in 32 bits. In that case the result equals A and the true carry/borrow is 1.

Flags:
- On the last limb, flag_c_o <= (alu_C_flag_i | lost) and flag_v_o <= alu_V_flag_i.
- Both hold until the next accepted start.
- nwords=0 clears both flags.

Optional Feature:
- Macro: ALU_MW_SEQ_ZFLAG_EN.
- Defined: adds output flag_z_o. It is 1 when every result limb of the operation is zero (AND-accumulated at capture), updated and held like flag_c_o, reset 0. nwords=0 gives flag_z_o=1.
- Undefined: the port and logic are absent.

Decomposition:
- Shared package alu_seq_pkg:
  - ALU mode constants ADD..PASS (0..7) as enum alu_mode_e.
  - Sequencer op encoding (OP_ADD=0, OP_SUB=1).
  - State enum seq_state_e {IDLE, RUN, DRAIN, DONE}.
- No sub-module: single FSM plus datapath registers. The ALU is instantiated outside the block.

Test Plan:
- 2-word add, A=0x00000001_FFFFFFFF, B=0x00000000_00000001 -> limbs 0x00000000 then 0x00000002; alu_ctrl 0 then 2; C=0, V=0; done_o one cycle after the last result handshake.
- 1-word sub 0x00000000-0x00000001 -> 0xFFFFFFFF, res_last_o=1, C=1, V=0.
- Lost-carry case, 2-word add, lo 0xFFFFFFFF+0x00000001, hi 0x12345678+0xFFFFFFFF -> limbs 0x00000000, 0x12345678; C=1.
- 1-word add 0x7FFFFFFF+0x00000001 -> 0x80000000, V=1, C=0.
- 3-word add with res_ready_i low for 3 cycles after the first result -> limb_ready_o low, res_data_o stable, all 3 limbs delivered in order, no loss or duplication.
- Edge cases:
  - nwords_i=0 -> done_o exactly 1 cycle after start, limb_ready_o never high.
  - rst_n low mid-RUN -> IDLE next cycle, no done_o.
